// File: rtl/hazard3_regfile_ctrl.sv
// ============================================================================
// Module   : hazard3_regfile_ctrl
// Purpose  : Arbitrates the core writeback port and a debug access port onto
//            the register file, with an optional clear-on-reset sequence that
//            is enabled by defining HAZARD3_REGFILE_CLEAR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard3_regfile_ctrl #(
    parameter int N_REGS = 32,
    parameter int W_DATA = 32,
    parameter int W_ADDR = $clog2(N_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              core_wen,
    input  logic [W_ADDR-1:0] core_waddr,
    input  logic [W_DATA-1:0] core_wdata,
    input  logic [W_ADDR-1:0] core_raddr2,
    output logic              core_stall,

    input  logic              dbg_req,
    input  logic              dbg_write,
    input  logic [W_ADDR-1:0] dbg_addr,
    input  logic [W_DATA-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [W_DATA-1:0] dbg_rdata,

    output logic              rf_wen,
    output logic [W_ADDR-1:0] rf_waddr,
    output logic [W_DATA-1:0] rf_wdata,
    output logic [W_ADDR-1:0] rf_raddr2,
    input  logic [W_DATA-1:0] rf_rdata2,

    output logic              init_done
);

    localparam logic [1:0] c_RUN = 2'd1;
    localparam logic [1:0] c_DRD = 2'd2;
`ifdef HAZARD3_REGFILE_CLEAR_EN
    localparam logic [1:0]        c_CLEAR       = 2'd0;
    localparam logic [1:0]        c_RESET_STATE = c_CLEAR;
    localparam logic [W_ADDR-1:0] c_CLR_LAST    = W_ADDR'(N_REGS - 1);
`else
    localparam logic [1:0]        c_RESET_STATE = c_RUN;
`endif

    logic [1:0] r_state;
    logic [1:0] w_next_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_RESET_STATE;
        end else begin
            r_state <= w_next_state;
        end
    end

`ifdef HAZARD3_REGFILE_CLEAR_EN
    logic [W_ADDR-1:0] r_clr_cnt;
    logic              r_init_done;
    logic              w_clr_last;

    assign w_clr_last = (r_clr_cnt == c_CLR_LAST);

    // Counter parks on the last entry so it never wraps while leaving CLEAR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_cnt   <= '0;
            r_init_done <= 1'b0;
        end else if (r_state == c_CLEAR) begin
            if (w_clr_last) begin
                r_init_done <= 1'b1;
            end else begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
        end
    end

    assign init_done = r_init_done;
`else
    assign init_done = 1'b1;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
`ifdef HAZARD3_REGFILE_CLEAR_EN
            c_CLEAR: begin
                if (w_clr_last) begin
                    w_next_state = c_RUN;
                end
            end
`endif
            c_RUN: begin
                if (dbg_req && !dbg_write) begin
                    w_next_state = c_DRD;
                end
            end
            c_DRD: begin
                w_next_state = c_RUN;
            end
            default: begin
                w_next_state = c_RESET_STATE;
            end
        endcase
    end

    always_comb begin
        rf_wen     = 1'b0;
        rf_waddr   = core_waddr;
        rf_wdata   = core_wdata;
        rf_raddr2  = core_raddr2;
        core_stall = 1'b0;
        dbg_ack    = 1'b0;
        dbg_rdata  = '0;
        case (r_state)
`ifdef HAZARD3_REGFILE_CLEAR_EN
            c_CLEAR: begin
                rf_wen     = 1'b1;
                rf_waddr   = r_clr_cnt;
                rf_wdata   = '0;
                core_stall = 1'b1;
            end
`endif
            c_RUN: begin
                // Core writeback wins the write port; a debug write waits.
                if (core_wen) begin
                    rf_wen = 1'b1;
                end else if (dbg_req && dbg_write) begin
                    rf_wen   = 1'b1;
                    rf_waddr = dbg_addr;
                    rf_wdata = dbg_wdata;
                    dbg_ack  = 1'b1;
                end
                if (dbg_req && !dbg_write) begin
                    rf_raddr2 = dbg_addr;
                end
            end
            c_DRD: begin
                // Read port 2 carries debug data this cycle, so the core retries.
                rf_wen     = core_wen;
                dbg_ack    = 1'b1;
                dbg_rdata  = rf_rdata2;
                core_stall = 1'b1;
            end
            default: begin
                core_stall = 1'b1;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_hazard3_regfile_ctrl.sv
// Testbench for hazard3_regfile_ctrl: behavioural regfile plus a debug-ack
// scoreboard; follows the DUT build via HAZARD3_REGFILE_CLEAR_EN.
`default_nettype none

module tb_hazard3_regfile_ctrl;

`ifdef HAZARD3_REGFILE_CLEAR_EN
    localparam int c_CLR     = 32;
    localparam bit c_HAS_CLR = 1'b1;
`else
    localparam int c_CLR     = 0;
    localparam bit c_HAS_CLR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_wen;
    logic [4:0]  core_waddr;
    logic [31:0] core_wdata;
    logic [4:0]  core_raddr2;
    logic        core_stall;
    logic        dbg_req;
    logic        dbg_write;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata2;
    logic        init_done;

    typedef struct packed {
        logic        is_rd;
        logic [31:0] data;
    } sb_t;

    sb_t         sb_q[$];
    sb_t         mon_e;
    logic [31:0] mem      [32];
    logic [31:0] exp_regs [32];
    int          n_checks = 0;
    int          n_errors = 0;

    hazard3_regfile_ctrl #(
        .N_REGS (32),
        .W_DATA (32),
        .W_ADDR (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .core_wen    (core_wen),
        .core_waddr  (core_waddr),
        .core_wdata  (core_wdata),
        .core_raddr2 (core_raddr2),
        .core_stall  (core_stall),
        .dbg_req     (dbg_req),
        .dbg_write   (dbg_write),
        .dbg_addr    (dbg_addr),
        .dbg_wdata   (dbg_wdata),
        .dbg_ack     (dbg_ack),
        .dbg_rdata   (dbg_rdata),
        .rf_wen      (rf_wen),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .rf_raddr2   (rf_raddr2),
        .rf_rdata2   (rf_rdata2),
        .init_done   (init_done)
    );

    always #5 clk = ~clk;

    // Register file: synchronous write, one-cycle registered read (old data on collision).
    always @(posedge clk) begin
        if (rf_wen) mem[rf_waddr] <= rf_wdata;
        rf_rdata2 <= mem[rf_raddr2];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Every ack consumes one scoreboard entry; reads also check the returned data.
    always @(negedge clk) begin
        if (dbg_ack) begin
            if (sb_q.size() == 0) begin
                check_val("unexp_ack", {31'b0, dbg_ack}, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.is_rd) check_val("dbg_rdata", dbg_rdata, mon_e.data);
            end
        end else begin
            check_val("rdata_idle", dbg_rdata, 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_clear_seq(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_val("clr_wen", {31'b0, rf_wen}, 32'd1);
            check_val("clr_waddr", {27'b0, rf_waddr}, i);
            check_val("clr_wdata", rf_wdata, 32'd0);
            check_val("clr_init", {31'b0, init_done}, 32'd0);
            check_val("clr_stall", {31'b0, core_stall}, 32'd1);
            check_val("clr_ack", {31'b0, dbg_ack}, 32'd0);
            tick();
        end
    endtask

    task automatic dbg_access(input bit wr, input logic [4:0] a, input logic [31:0] d);
        bit got;
        sb_q.push_back('{is_rd: !wr, data: (wr ? 32'd0 : exp_regs[a])});
        if (wr) exp_regs[a] = d;
        dbg_req   = 1'b1;
        dbg_write = wr;
        dbg_addr  = a;
        dbg_wdata = d;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (dbg_ack) got = 1'b1;
            tick();
        end
        check_val("dbg_ack_seen", {31'b0, got}, 32'd1);
        dbg_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        core_wen = 1'b0; core_waddr = '0; core_wdata = '0; core_raddr2 = '0;
        dbg_req = 1'b0; dbg_write = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        for (int i = 0; i < 32; i++) exp_regs[i] = '0;
        repeat (2) tick();

        @(negedge clk);
        check_val("rst_ack", {31'b0, dbg_ack}, 32'd0);
        check_val("rst_wen", {31'b0, rf_wen}, {31'b0, c_HAS_CLR});
        check_val("rst_stall", {31'b0, core_stall}, {31'b0, c_HAS_CLR});
        check_val("rst_init", {31'b0, init_done}, {31'b0, !c_HAS_CLR});
        if (c_HAS_CLR) check_val("rst_waddr", {27'b0, rf_waddr}, 32'd0);
        tick();

        // Release reset with a debug write already pending: acked on the first RUN cycle.
        rst_n = 1'b1;
        sb_q.push_back('{is_rd: 1'b0, data: 32'd0});
        dbg_req = 1'b1; dbg_write = 1'b1; dbg_addr = 5'd3; dbg_wdata = 32'h0000_0333;
        exp_regs[3] = 32'h0000_0333;
        check_clear_seq(c_CLR);
        @(negedge clk);
        check_val("run_init", {31'b0, init_done}, 32'd1);
        check_val("run_stall", {31'b0, core_stall}, 32'd0);
        check_val("first_ack", {31'b0, dbg_ack}, 32'd1);
        check_val("first_waddr", {27'b0, rf_waddr}, 32'd3);
        check_val("first_wdata", rf_wdata, 32'h0000_0333);
        tick();
        dbg_req = 1'b0;

        // Core write and debug write collide: core first, debug next cycle.
        core_wen = 1'b1; core_waddr = 5'd5; core_wdata = 32'h5555_0005;
        exp_regs[5] = 32'h5555_0005;
        sb_q.push_back('{is_rd: 1'b0, data: 32'd0});
        dbg_req = 1'b1; dbg_write = 1'b1; dbg_addr = 5'd6; dbg_wdata = 32'h6666_0006;
        exp_regs[6] = 32'h6666_0006;
        @(negedge clk);
        check_val("col_waddr1", {27'b0, rf_waddr}, 32'd5);
        check_val("col_wdata1", rf_wdata, 32'h5555_0005);
        check_val("col_ack1", {31'b0, dbg_ack}, 32'd0);
        tick();
        core_wen = 1'b0;
        @(negedge clk);
        check_val("col_wen2", {31'b0, rf_wen}, 32'd1);
        check_val("col_waddr2", {27'b0, rf_waddr}, 32'd6);
        check_val("col_wdata2", rf_wdata, 32'h6666_0006);
        check_val("col_ack2", {31'b0, dbg_ack}, 32'd1);
        tick();
        dbg_req = 1'b0;

        // Debug read of r7 with the core's read port pointed elsewhere.
        core_wen = 1'b1; core_waddr = 5'd7; core_wdata = 32'hDEAD_BEEF;
        exp_regs[7] = 32'hDEAD_BEEF;
        tick();
        core_wen = 1'b0;
        sb_q.push_back('{is_rd: 1'b1, data: exp_regs[7]});
        dbg_req = 1'b1; dbg_write = 1'b0; dbg_addr = 5'd7; core_raddr2 = 5'd2;
        @(negedge clk);
        check_val("rd_issue_raddr", {27'b0, rf_raddr2}, 32'd7);
        check_val("rd_issue_ack", {31'b0, dbg_ack}, 32'd0);
        check_val("rd_issue_stall", {31'b0, core_stall}, 32'd0);
        tick();
        @(negedge clk);
        check_val("rd_ack", {31'b0, dbg_ack}, 32'd1);
        check_val("rd_data", dbg_rdata, 32'hDEAD_BEEF);
        check_val("rd_stall", {31'b0, core_stall}, 32'd1);
        check_val("rd_core_raddr", {27'b0, rf_raddr2}, 32'd2);
        tick();
        dbg_req = 1'b0;
        @(negedge clk);
        check_val("rd_after_stall", {31'b0, core_stall}, 32'd0);
        tick();

        // Debug read racing a core write to the same register returns old data;
        // a core write presented during the read's second cycle still lands.
        sb_q.push_back('{is_rd: 1'b1, data: exp_regs[5]});
        dbg_req = 1'b1; dbg_write = 1'b0; dbg_addr = 5'd5;
        core_wen = 1'b1; core_waddr = 5'd5; core_wdata = 32'h1234_5678;
        exp_regs[5] = 32'h1234_5678;
        @(negedge clk);
        check_val("race_raddr", {27'b0, rf_raddr2}, 32'd5);
        check_val("race_wen", {31'b0, rf_wen}, 32'd1);
        check_val("race_waddr", {27'b0, rf_waddr}, 32'd5);
        tick();
        core_waddr = 5'd9; core_wdata = 32'h0000_9999;
        exp_regs[9] = 32'h0000_9999;
        @(negedge clk);
        check_val("drd_ack", {31'b0, dbg_ack}, 32'd1);
        check_val("drd_wen", {31'b0, rf_wen}, 32'd1);
        check_val("drd_waddr", {27'b0, rf_waddr}, 32'd9);
        check_val("drd_wdata", rf_wdata, 32'h0000_9999);
        tick();
        core_wen = 1'b0;
        dbg_req = 1'b0;
        dbg_access(1'b0, 5'd5, 32'd0);
        dbg_access(1'b0, 5'd9, 32'd0);

        for (int k = 0; k < 6; k++) begin
            logic [4:0]  a;
            logic [31:0] d;
            a = 5'($urandom_range(10, 31));
            d = $urandom;
            dbg_access(1'b1, a, d);
            dbg_access(1'b0, a, 32'd0);
        end

        // Reset during the read's ack cycle: the access is dropped, never acked.
        sb_q.push_back('{is_rd: 1'b1, data: exp_regs[6]});
        dbg_req = 1'b1; dbg_write = 1'b0; dbg_addr = 5'd6;
        @(negedge clk);
        check_val("abort_raddr", {27'b0, rf_raddr2}, 32'd6);
        tick();
        rst_n = 1'b0;
        dbg_req = 1'b0;
        sb_q.delete(sb_q.size() - 1);
        @(negedge clk);
        check_val("abort_ack", {31'b0, dbg_ack}, 32'd0);
        check_val("abort_stall", {31'b0, core_stall}, {31'b0, c_HAS_CLR});
        check_val("abort_wen", {31'b0, rf_wen}, {31'b0, c_HAS_CLR});
        tick();
        rst_n = 1'b1;
        check_clear_seq(c_CLR);
        @(negedge clk);
        check_val("abort_init", {31'b0, init_done}, 32'd1);
        check_val("abort_stall2", {31'b0, core_stall}, 32'd0);
        tick();
        if (c_HAS_CLR) begin
            for (int i = 0; i < 32; i++) exp_regs[i] = '0;
        end

`ifdef HAZARD3_REGFILE_CLEAR_EN
        // Reset pulse at clear entry 10 restarts the sequence from entry 0.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_clear_seq(10);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("pulse_waddr", {27'b0, rf_waddr}, 32'd0);
        tick();
        rst_n = 1'b1;
        check_clear_seq(32);
        @(negedge clk);
        check_val("pulse_init", {31'b0, init_done}, 32'd1);
        tick();
`endif

        dbg_access(1'b0, 5'd3, 32'd0);
        check_val("sb_empty", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard3_regfile_ctrl.md
HAZARD3_REGFILE_CTRL -- requirements
Module: hazard3_regfile_ctrl

Interface
REQ-001 SHALL have parameter N_REGS, default 32, number of regfile entries (power of two, >=2).
REQ-002 SHALL have parameter W_DATA, default 32, data width.
REQ-003 SHALL have parameter W_ADDR, default $clog2(N_REGS), register address width.
REQ-004 SHALL have port clk  input  1  sole clock, all state on posedge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports core_wen/core_waddr/core_wdata  input  1/W_ADDR/W_DATA  core writeback request.
REQ-007 SHALL have port core_raddr2  input  W_ADDR  core read-port-2 address.
REQ-008 SHALL have port core_stall  output  1  high: rdata2 this cycle is not the core's data; core re-presents the same core_raddr2 next cycle.
REQ-009 SHALL have ports dbg_req/dbg_write/dbg_addr/dbg_wdata  input  1/1/W_ADDR/W_DATA  debug access request, held until ack.
REQ-010 SHALL have ports dbg_ack/dbg_rdata  output  1/W_DATA  debug completion pulse and read data, valid with ack.
REQ-011 SHALL have ports rf_wen/rf_waddr/rf_wdata/rf_raddr2  output  1/W_ADDR/W_DATA/W_ADDR  to regfile write port and read port 2.
REQ-012 SHALL have port rf_rdata2  input  W_DATA  regfile read-port-2 data, one cycle after rf_raddr2.
REQ-013 SHALL have port init_done  output  1  high once the regfile clear sequence has completed.

Function
REQ-014 SHALL implement FSM states CLEAR, RUN, DRD; clear counter clr_cnt is W_ADDR bits wide.
REQ-015 In CLEAR, SHALL drive rf_wen=1, rf_waddr=clr_cnt, rf_wdata=0, and increment clr_cnt each cycle.
REQ-016 SHALL transition CLEAR->RUN on the cycle clr_cnt==N_REGS-1 is written (N_REGS cycles total), with no wrap back to 0.
REQ-017 In CLEAR, SHALL hold core_stall=1, dbg_ack=0, init_done=0, and ignore core_wen and dbg_req.
REQ-018 In RUN with core_wen=1, SHALL forward the core write to rf_* in the same cycle, combinationally, with priority over debug.
REQ-019 In RUN with dbg_req&dbg_write&!core_wen, SHALL drive the debug write to rf_* and assert dbg_ack in the same cycle.
REQ-020 In RUN with dbg_req&!dbg_write, SHALL drive rf_raddr2=dbg_addr and go to DRD; a concurrent core_wen is still performed.
REQ-021 In DRD, SHALL assert dbg_ack=1, dbg_rdata=rf_rdata2, core_stall=1, rf_raddr2=core_raddr2, forward core_wen, and return to RUN.
REQ-022 Outside the debug-read issue cycle, SHALL drive rf_raddr2=core_raddr2.
REQ-023 When dbg_ack=0, SHALL drive dbg_rdata=0.
REQ-024 SHALL assert dbg_ack for exactly one cycle per request; a dbg_req still high after ack starts a new access.
REQ-025 A debug read of a register written by the core in the issue cycle SHALL return the old value (no bypass).

Reset
REQ-026 On rst_n low, SHALL set state=CLEAR, clr_cnt=0, init_done=0; while in reset, outputs SHALL be rf_wen=1, rf_waddr=0, rf_wdata=0, dbg_ack=0, core_stall=1.
REQ-027 Reset asserted mid-CLEAR or mid-DRD SHALL abort the operation; the clear SHALL restart from entry 0, and the aborted debug access SHALL not be acked.

Configuration
REQ-028 Macro HAZARD3_REGFILE_CLEAR_EN defined: CLEAR state and clr_cnt present as above.
REQ-029 Macro HAZARD3_REGFILE_CLEAR_EN undefined: reset state SHALL be RUN, init_done SHALL be constant 1, no clear writes SHALL occur, and clr_cnt SHALL be absent.

Verification
REQ-030 Release rst_n, N_REGS=32 -> rf_wen high 32 cycles with waddr 0..31 and wdata 0; init_done rises in cycle 33; core_stall low afterwards.
REQ-031 RUN, core_wen=1 waddr=5 and dbg write addr=6 in the same cycle -> cycle 1 writes r5, dbg_ack=0; cycle 2 writes r6, dbg_ack=1.
REQ-032 RUN, r7=0xDEADBEEF, dbg read addr=7 -> issue cycle rf_raddr2=7; next cycle dbg_ack=1, dbg_rdata=0xDEADBEEF, core_stall=1.
REQ-033 dbg_req held through CLEAR -> no ack until RUN; ack occurs in the first RUN cycle (write) or the second (read).
REQ-034 rst_n pulsed low at clear entry 10 -> counter restarts at 0; full 32-entry clear observed; no dbg_ack issued.
REQ-035 Build without HAZARD3_REGFILE_CLEAR_EN -> init_done=1 and debug write acked in the first cycle after reset release.
